// File: rtl/beta_mem_arbiter.sv
// beta_mem_arbiter: serialises Beta instruction fetch and load/store onto one memory port.
// Each Beta cycle is FETCH, optional DATA, then a single non-stalled RELEASE cycle.
module beta_mem_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstructionAddress,
  output logic [31:0] InstructionData,
  input  logic [31:0] DataAddress,
  input  logic [31:0] DataWrite,
  input  logic        WriteEnable,
  input  logic        ReadEnable,
  output logic [31:0] DataRead,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_error
);
  typedef enum logic [1:0] {FETCH, DATA, RELEASE} state_t;
  state_t      state, stateNext;
  logic        live;
  logic [7:0]  waitCnt;
  logic        timedOut, done, isLoad;
  logic [3:0]  unusedLowBits;
  assign unusedLowBits = {InstructionAddress[1:0], DataAddress[1:0]};
  // live holds mem_req off until the first clock edge after reset release
  assign mem_req = live && state != RELEASE;
  assign stall   = state != RELEASE;
  assign isLoad  = ReadEnable && !WriteEnable;
  always_comb begin
    mem_we    = mem_req && state == DATA && WriteEnable;
    mem_addr  = !mem_req ? '0 : state == DATA ? {DataAddress[31:2], 2'b00} : {InstructionAddress[31:2], 2'b00};
    mem_wdata = (mem_req && state == DATA) ? DataWrite : '0;
    timedOut  = mem_req && !mem_ack && waitCnt == 8'(TIMEOUT);
    done      = mem_req && (mem_ack || timedOut);
    stateNext = state == RELEASE ? FETCH :
                !done ? state :
                (state == FETCH && (ReadEnable || WriteEnable)) ? DATA : RELEASE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= FETCH;
      live            <= 1'b0;
      waitCnt         <= '0;
      InstructionData <= '0;
      DataRead        <= '0;
      bus_error       <= 1'b0;
    end else begin
      live    <= 1'b1;
      state   <= stateNext;
      waitCnt <= (done || !mem_req) ? 8'd0 : waitCnt + 8'd1;
      if (timedOut)
        bus_error <= 1'b1;
      if (done && state == FETCH)
        InstructionData <= mem_ack ? mem_rdata : ERR_WORD;
      // a cycle without a load always ends with DataRead cleared
      if (done && stateNext == RELEASE)
        DataRead <= (state == DATA && isLoad) ? (mem_ack ? mem_rdata : ERR_WORD) : '0;
    end
  end
endmodule

// File: tb/tb_beta_mem_arbiter.sv
// tb_beta_mem_arbiter: transaction-level model of the arbiter, checked every cycle.
module tb_beta_mem_arbiter;
  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] InstructionAddress = 0, DataAddress = 0, DataWrite = 0, mem_rdata = 0;
  logic        WriteEnable = 0, ReadEnable = 0, mem_ack = 0;
  logic [31:0] InstructionData, DataRead, mem_addr, mem_wdata;
  logic        stall, mem_req, mem_we, bus_error;
  int          nChk = 0, nFail = 0;
  logic        errSticky = 0;
  always #5 clk = ~clk;
  beta_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .InstructionAddress(InstructionAddress), .InstructionData(InstructionData),
    .DataAddress(DataAddress), .DataWrite(DataWrite),
    .WriteEnable(WriteEnable), .ReadEnable(ReadEnable), .DataRead(DataRead),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_error(bus_error)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // One Beta cycle: wf/wd are ack wait counts per beat (above TO means never acked).
  task automatic run(input logic [31:0] ia, da, dw, input logic we, re,
                     input int wf, wd, input logic [31:0] rf, rd);
    int          nb, w[2];
    logic [31:0] a[2], d[2], expI, expD;
    logic        wb[2];
    nb = (we || re) ? 2 : 1;
    w[0] = wf; w[1] = wd; d[0] = rf; d[1] = rd;
    a[0] = {ia[31:2], 2'b00}; a[1] = {da[31:2], 2'b00};
    wb[0] = 1'b0; wb[1] = we;
    expI = wf > TO ? ERR : rf;
    expD = (re && !we) ? (wd > TO ? ERR : rd) : 32'h0;
    if (wf > TO || (nb == 2 && wd > TO)) errSticky = 1'b1;
    @(posedge clk); #1;
    InstructionAddress = ia; DataAddress = da; DataWrite = dw;
    WriteEnable = we; ReadEnable = re; mem_ack = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c <= TO; c++) begin
        @(negedge clk);
        chk("beat_stall", {31'b0, stall}, 1);
        chk("beat_req", {31'b0, mem_req}, 1);
        chk("beat_addr", mem_addr, a[b]);
        chk("beat_we", {31'b0, mem_we}, {31'b0, wb[b]});
        if (b == 1) chk("beat_wdata", mem_wdata, dw);
        mem_ack = (c == w[b]);
        mem_rdata = d[b];
        if (mem_ack) break;
      end
    end
    @(negedge clk);
    chk("rel_stall", {31'b0, stall}, 0);
    chk("rel_req", {31'b0, mem_req}, 0);
    chk("rel_instr", InstructionData, expI);
    chk("rel_dread", DataRead, expD);
    chk("rel_buserr", {31'b0, bus_error}, {31'b0, errSticky});
    mem_ack = 1;
    mem_rdata = 32'hBAD0BAD0;
  endtask
  task automatic chkReset();
    chk("rst_stall", {31'b0, stall}, 1);
    chk("rst_req", {31'b0, mem_req}, 0);
    chk("rst_we", {31'b0, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_instr", InstructionData, 0);
    chk("rst_dread", DataRead, 0);
    chk("rst_buserr", {31'b0, bus_error}, 0);
  endtask
  initial begin
    #12;
    chkReset();
    @(negedge clk); rst_n = 1;
    #1 chk("req_after_release", {31'b0, mem_req}, 0);
    run(32'h10, 32'h0, 32'h0, 0, 0, 0, 0, 32'h601F0004, 0);
    chk("pin_fetch", InstructionData, 32'h601F0004);
    run(32'h20, 32'h103, 32'h0, 0, 1, 0, 3, 32'h00000001, 32'hCAFEF00D);
    chk("pin_load", DataRead, 32'hCAFEF00D);
    run(32'h24, 32'h200, 32'h12345678, 1, 0, 1, 2, 32'h00000002, 32'h0);
    chk("pin_store_dread", DataRead, 32'h0);
    run(32'h28, 32'h40, 32'hA5A5A5A5, 1, 1, 0, 1, 32'h00000003, 32'h77777777);
    run(32'h2C, 32'h44, 32'h0, 0, 1, 2, TO, 32'h00000004, 32'h13572468);
    chk("pin_ack_on_timeout_err", {31'b0, bus_error}, 0);
    run(32'h37, 32'h0, 32'h0, 0, 0, 2, 0, 32'h00000005, 0);
    run(32'h40, 32'h500, 32'h0, 0, 1, 255, 255, 32'h1, 32'h2);
    chk("pin_timeout_dread", DataRead, 32'hDEADBEEF);
    chk("pin_timeout_err", {31'b0, bus_error}, 1);
    run(32'h44, 32'h0, 32'h0, 0, 0, 0, 0, 32'h00000006, 0);
    run(32'h48, 32'h600, 32'hFFFF0000, 1, 0, 1, 255, 32'h00000007, 0);
    @(posedge clk); #1;
    InstructionAddress = 32'h50; DataAddress = 32'h300; ReadEnable = 1; WriteEnable = 0; mem_ack = 0;
    @(negedge clk); mem_ack = 1; mem_rdata = 32'h11111111;
    @(negedge clk); mem_ack = 0;
    chk("mid_data_req", {31'b0, mem_req}, 1);
    chk("mid_data_addr", mem_addr, 32'h300);
    #1 rst_n = 0; mem_ack = 1;
    #1 chkReset();
    errSticky = 0;
    @(negedge clk); rst_n = 1;
    #1 chk("req_after_rerelease", {31'b0, mem_req}, 0);
    run(32'h60, 32'h0, 32'h0, 0, 0, 1, 0, 32'h0000ABCD, 0);
    run(32'h64, 32'h104, 32'h0, 0, 1, 0, 0, 32'h0000ABCE, 32'h55AA55AA);
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule

// File: doc/beta_mem_arbiter.md
BETA_MEM_ARBITER -- requirements
Module: beta_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for mem_ack per request (range 1..255).
REQ-002 SHALL have parameter ERR_WORD, default 32'hDEADBEEF, giving the data returned on a timed-out read.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 InstructionAddress  input  32  Beta fetch byte address.
REQ-006 InstructionData  output  32  fetched instruction word to Beta.
REQ-007 DataAddress  input  32  Beta load/store byte address.
REQ-008 DataWrite  input  32  Beta store data.
REQ-009 WriteEnable  input  1  Beta store request.
REQ-010 ReadEnable  input  1  Beta load request.
REQ-011 DataRead  output  32  load data to Beta.
REQ-012 stall  output  1  high = Beta must hold state this cycle.
REQ-013 mem_req  output  1  request to the single-ported memory.
REQ-014 mem_we  output  1  request is a write when high.
REQ-015 mem_addr  output  32  word-aligned byte address (bits [1:0] = 0).
REQ-016 mem_wdata  output  32  write data.
REQ-017 mem_ack  input  1  memory completion strobe, sampled at posedge.
REQ-018 mem_rdata  input  32  read data, valid when mem_ack high.
REQ-019 bus_error  output  1  sticky timeout flag.

Function
REQ-020 SHALL serialise each Beta cycle onto the memory port with FSM states FETCH, DATA, RELEASE.
REQ-021 FETCH: mem_req=1, mem_we=0, mem_addr={InstructionAddress[31:2],2'b00}; on mem_ack, capture mem_rdata into the instruction register; go to DATA if ReadEnable|WriteEnable, else RELEASE.
REQ-022 DATA: mem_req=1, mem_we=WriteEnable, mem_addr={DataAddress[31:2],2'b00}, mem_wdata=DataWrite; on mem_ack, capture mem_rdata into the data register if ReadEnable; go to RELEASE.
REQ-023 If WriteEnable and ReadEnable are both high, SHALL perform the write only and set DataRead to 0.
REQ-024 RELEASE: mem_req=0, stall=0 for exactly one cycle; next state FETCH.
REQ-025 stall SHALL be 1 in FETCH and DATA, 0 only in RELEASE.
REQ-026 InstructionData and DataRead SHALL be driven from registers, stable from RELEASE entry until the next capture; DataRead=0 when the cycle had no load.
REQ-027 mem_addr, mem_we and mem_wdata SHALL stay constant while mem_req=1 and mem_ack=0.
REQ-028 mem_ack while mem_req=0 SHALL be ignored.
REQ-029 Minimum latency: fetch-only cycle = 2 clocks with zero-wait ack; fetch+data = 3 clocks.
REQ-030 An 8-bit wait counter SHALL clear on entering FETCH or DATA and increment each cycle without ack; when it reaches TIMEOUT, the state SHALL complete as if acked, with captured data = ERR_WORD, and set bus_error.
REQ-031 A timed-out write SHALL be dropped; bus_error SHALL stay set until reset.
REQ-032 mem_ack coinciding with the timeout cycle SHALL take priority: use mem_rdata, no error.

Reset
REQ-033 On rst_n=0, asynchronously: state=FETCH, stall=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, InstructionData=0, DataRead=0, bus_error=0, counter=0.
REQ-034 mem_req SHALL rise no earlier than the first posedge after rst_n deasserts.
REQ-035 Reset mid-transaction SHALL abandon the transaction; a late mem_ack after reset SHALL be ignored unless mem_req=1.

Verification
REQ-036 Fetch-only: IA=0x10, RE=WE=0, ack zero-wait, rdata=0x601F0004 -> stall 1,0; InstructionData=0x601F0004 in RELEASE; one mem_req beat with addr 0x10.
REQ-037 Load: IA=0x20, DA=0x103, RE=1, ack after 3 waits, rdata 0xCAFEF00D -> data beat with mem_addr=0x100; DataRead=0xCAFEF00D; stall low exactly 1 cycle.
REQ-038 Store: DA=0x200, WE=1, DataWrite=0x12345678 -> mem_we=1, wdata stable across waits; DataRead=0.
REQ-039 Timeout: TIMEOUT=4, mem_ack never asserted on load -> after 4 wait cycles per state, DataRead=0xDEADBEEF, bus_error=1 and sticky.
REQ-040 Reset mid-DATA: assert rst_n=0 while mem_req=1 -> mem_req=0 immediately, outputs at reset values, restart in FETCH.
REQ-041 RE=WE=1 with DA=0x40 -> single write beat, DataRead=0.
